// File: rtl/tlb_wrr_arbiter_pkg.sv
// Shared types and constants for the weighted round-robin DMA request arbiter.
// The ID width helper keeps single-bit IDs legal for the smallest configurations.
package tlb_wrr_arbiter_pkg;

   localparam int ARB_N_CH    = 4;
   localparam int DEF_WEIGHT  = 1;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [id_width(ARB_N_CH)-1:0] arb_id_t;

endpackage

// File: rtl/tlb_wrr_seq_fifo.sv
// First-word-fall-through FIFO holding granted channel IDs in grant order.
// The caller never pushes when full nor pops when empty.
module tlb_wrr_seq_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;

   always_ff @(posedge aclk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/tlb_wrr_arbiter.sv
// Weighted round-robin merge of per-region DMA request streams onto one request port,
// with per-channel outstanding caps and an in-order grant-ID stream for the data mux.
module tlb_wrr_arbiter
   import tlb_wrr_arbiter_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int REQ_BITS  = 128,
   parameter int W_BITS    = 4,
   parameter int MAX_OUT   = 8,
   parameter int SEQ_DEPTH = 16,
   parameter int ID_BITS   = id_width(N_CH)
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [N_CH-1:0]          s_req_valid,
   output logic [N_CH-1:0]          s_req_ready,
   input  logic [N_CH*REQ_BITS-1:0] s_req_data,
   input  logic [N_CH*W_BITS-1:0]   weight,
   output logic                     m_req_valid,
   input  logic                     m_req_ready,
   output logic [REQ_BITS-1:0]      m_req_data,
   output logic [ID_BITS-1:0]       m_req_id,
   input  logic                     done_valid,
   input  logic [ID_BITS-1:0]       done_id,
   output logic                     m_seq_valid,
   output logic [ID_BITS-1:0]       m_seq_id,
   input  logic                     m_seq_ready,
   output logic                     err_done
);

   localparam int OC_BITS = $clog2(MAX_OUT + 1);
   localparam int FC_BITS = $clog2(SEQ_DEPTH) + 1;
   localparam logic [OC_BITS-1:0] MAX_OUT_C   = OC_BITS'(MAX_OUT);
   localparam logic [FC_BITS-1:0] SEQ_DEPTH_C = FC_BITS'(SEQ_DEPTH);
   localparam logic [ID_BITS:0]   N_CH_C      = (ID_BITS + 1)'(N_CH);

   logic [W_BITS-1:0]   w_ch   [N_CH];
   logic [REQ_BITS-1:0] req_ch [N_CH];
   logic [OC_BITS-1:0]  out_cnt_reg [N_CH];
   logic [N_CH-1:0]     eligible;
   logic [N_CH-1:0]     cnt_inc;
   logic [N_CH-1:0]     cnt_dec;

   logic [ID_BITS-1:0]  cur_reg, cur_next;
   logic [W_BITS-1:0]   bcnt_reg, bcnt_next;
   logic                m_req_valid_reg;
   logic [REQ_BITS-1:0] m_req_data_reg;
   logic [ID_BITS-1:0]  m_req_id_reg;
   logic                err_done_reg;

   logic                can_issue;
   logic                grant_any;
   logic [ID_BITS-1:0]  grant_id;
   logic [ID_BITS:0]    scan_pos;

   logic                fifo_empty;
   logic [FC_BITS-1:0]  fifo_count;
   logic                fifo_pop;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_ch[gi]        = weight[gi*W_BITS +: W_BITS];
      assign req_ch[gi]      = s_req_data[gi*REQ_BITS +: REQ_BITS];
      assign eligible[gi]    = s_req_valid[gi] && (w_ch[gi] != '0) && (out_cnt_reg[gi] < MAX_OUT_C);
      assign s_req_ready[gi] = grant_any && (grant_id == ID_BITS'(gi));
      assign cnt_inc[gi]     = s_req_ready[gi];
      // A completion only counts against a channel that actually has something in flight.
      assign cnt_dec[gi]     = done_valid && (done_id == ID_BITS'(gi)) && (out_cnt_reg[gi] != '0);
   end

   // Holding reset off the grant path keeps every ready low while reset is applied.
   assign can_issue = !areset && (!m_req_valid_reg || m_req_ready) && (fifo_count < SEQ_DEPTH_C);

   always_comb begin
      grant_any = 1'b0;
      grant_id  = cur_reg;
      cur_next  = cur_reg;
      bcnt_next = bcnt_reg;
      scan_pos  = '0;
      if (can_issue) begin
         if (eligible[cur_reg] && (bcnt_reg < w_ch[cur_reg])) begin
            grant_any = 1'b1;
            bcnt_next = bcnt_reg + 1'b1;
         end else begin
            // Walk from farthest to nearest so the closest eligible channel after cur wins.
            for (int k = N_CH; k >= 1; k--) begin
               scan_pos = {1'b0, cur_reg} + (ID_BITS + 1)'(k);
               if (scan_pos >= N_CH_C) scan_pos = scan_pos - N_CH_C;
               if (eligible[scan_pos[ID_BITS-1:0]]) begin
                  grant_any = 1'b1;
                  grant_id  = scan_pos[ID_BITS-1:0];
               end
            end
            if (grant_any) begin
               cur_next  = grant_id;
               bcnt_next = W_BITS'(1);
            end
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cur_reg         <= '0;
         bcnt_reg        <= '0;
         m_req_valid_reg <= 1'b0;
         m_req_data_reg  <= '0;
         m_req_id_reg    <= '0;
         err_done_reg    <= 1'b0;
      end else begin
         cur_reg  <= cur_next;
         bcnt_reg <= bcnt_next;
         if (grant_any) begin
            m_req_valid_reg <= 1'b1;
            m_req_data_reg  <= req_ch[grant_id];
            m_req_id_reg    <= grant_id;
         end else if (m_req_ready) begin
            m_req_valid_reg <= 1'b0;
         end
         if (done_valid && !(|cnt_dec)) err_done_reg <= 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < N_CH; i++) out_cnt_reg[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (cnt_inc[i] && !cnt_dec[i]) begin
               out_cnt_reg[i] <= out_cnt_reg[i] + 1'b1;
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
               out_cnt_reg[i] <= out_cnt_reg[i] - 1'b1;
            end
         end
      end
   end

   assign fifo_pop = m_seq_ready && !fifo_empty;

   tlb_wrr_seq_fifo #(
      .DEPTH (SEQ_DEPTH),
      .WIDTH (ID_BITS)
   ) u_seq_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .push      (grant_any),
      .push_data (grant_id),
      .pop       (fifo_pop),
      .head      (m_seq_id),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign m_req_valid = m_req_valid_reg;
   assign m_req_data  = m_req_data_reg;
   assign m_req_id    = m_req_id_reg;
   assign m_seq_valid = !fifo_empty;
   assign err_done    = err_done_reg;

endmodule
